// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//
// Memory-access stage of a simple pipeline. Loads and stores coming out of
// EX/MEM are turned into a request/acknowledge transaction on an external
// data-memory port. While the transaction is in flight the stage stalls
// upstream and the MEM/WB register. Non-memory instructions pass straight
// through with no added latency.
//
// Each aligned access takes 1 accept cycle, then N BUSY cycles (the ack
// arrives in the Nth), then 1 DONE cycle. The DONE cycle is the only cycle
// with stall_o low, so MEM/WB sees exactly one valid beat per instruction.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   MemRead_i, MemWrite_i     load / store request (both high = store)
//   ALUResult_i               effective address, or pass-through result
//   WriteData_i               store data
//   RDaddr_i, RegWrite_i,
//   MemToReg_i                destination register and write-back control
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o   external data-memory request
//   mem_ack_i, mem_rdata_i    memory completion and load data
//   RDData_o, ALUResult_o,
//   RDaddr_o, RegWrite_o,
//   MemToReg_o                results for MEM/WB
//   stall_o                   freeze upstream and the MEM/WB input this cycle
//   misalign_o, bus_err_o     single-cycle error pulses
// -----------------------------------------------------------------------------
module mem_access #(
  parameter int TIMEOUT = 255   // max BUSY cycles without ack, 1..255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] WriteData_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] RDData_o,
  output logic [31:0] ALUResult_o,
  output logic [4:0]  RDaddr_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value at which a BUSY cycle without ack becomes a bus error.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        we_reg;
  logic [4:0]  rd_reg;
  logic        regwrite_reg;
  logic        memtoreg_reg;
  logic [7:0]  count_reg;

  logic access;
  logic aligned;
  logic timeout_hit;

  assign access      = MemRead_i | MemWrite_i;
  assign aligned     = (ALUResult_i[1:0] == 2'b00);
  assign timeout_hit = (count_reg == LAST_COUNT);

  // ---------------------------------------------------------------------------
  // State machine and captured instruction context
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      we_reg       <= 1'b0;
      rd_reg       <= '0;
      regwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      count_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (access && aligned) begin
            addr_reg     <= ALUResult_i;
            wdata_reg    <= WriteData_i;
            we_reg       <= MemWrite_i;   // store wins when both are high
            rd_reg       <= RDaddr_i;
            regwrite_reg <= RegWrite_i;
            memtoreg_reg <= MemToReg_i;
            count_reg    <= '0;
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          // Ack has priority over a timeout landing in the same cycle.
          if (mem_ack_i) begin
            rdata_reg <= we_reg ? 32'h0 : mem_rdata_i;
            state_reg <= DONE;
          end else if (timeout_hit) begin
            rdata_reg    <= 32'hDEAD_BEEF;
            regwrite_reg <= 1'b0;         // never write back a failed access
            state_reg    <= DONE;
          end else begin
            count_reg <= count_reg + 8'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. IDLE is transparent to upstream; BUSY and DONE present the
  // captured context so late upstream changes cannot leak through.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    RDData_o    = '0;
    ALUResult_o = '0;
    RDaddr_o    = '0;
    RegWrite_o  = 1'b0;
    MemToReg_o  = 1'b0;
    stall_o     = 1'b0;
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;

    // Reset silences everything, including an access that was mid-flight.
    if (!rst_i) begin
      case (state_reg)
        IDLE: begin
          ALUResult_o = ALUResult_i;
          RDaddr_o    = RDaddr_i;
          MemToReg_o  = MemToReg_i;
          if (!access) begin
            RegWrite_o = RegWrite_i;
          end else if (!aligned) begin
            misalign_o = 1'b1;
            MemToReg_o = 1'b0;
          end else begin
            stall_o = 1'b1;
          end
        end
        BUSY: begin
          mem_req_o   = 1'b1;
          mem_we_o    = we_reg;
          mem_addr_o  = addr_reg;
          mem_wdata_o = wdata_reg;
          ALUResult_o = addr_reg;
          RDaddr_o    = rd_reg;
          MemToReg_o  = memtoreg_reg;
          stall_o     = 1'b1;
          bus_err_o   = timeout_hit & ~mem_ack_i;
        end
        DONE: begin
          RDData_o    = rdata_reg;
          ALUResult_o = addr_reg;
          RDaddr_o    = rd_reg;
          RegWrite_o  = regwrite_reg;
          MemToReg_o  = memtoreg_reg;
        end
        default: begin
          stall_o = 1'b0;
        end
      endcase
    end
  end

endmodule
